// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control FSM: default sizing, state
// encoding and the reserved destination address.
package router_pkg;

  localparam int NUM_PORTS_DEF = 3;
  localparam int ADDR_W_DEF    = 2;

  // Header address that no output FIFO answers to.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
    , DROP_PACKET      = 4'd8
`endif
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Moore control FSM sequencing the router register block and FIFO writes.
// Optional macro ROUTER_FSM_BAD_ADDR_DROP_EN adds a DROP_PACKET state for bad headers.
//
// state              | meaning
// -------------------+--------------------------------------------------
// DECODE_ADDRESS     | idle, examining each valid byte as a header
// WAIT_TILL_EMPTY    | header accepted, target FIFO still draining
// LOAD_FIRST_DATA    | header byte written to the FIFO
// LOAD_DATA          | payload bytes streaming into the FIFO
// FIFO_FULL_STATE    | target FIFO full, input stalled
// LOAD_AFTER_FULL    | write back the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | clear register-block flags, parity compared
// DROP_PACKET        | (macro only) swallowing a packet with a bad address
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    cur_addr
);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic                w_addr_in_range;
  logic                w_hdr_valid;
  logic                w_sel_empty;
  logic                w_cur_empty;
  logic                w_cur_soft_rst;

  assign w_addr_in_range = (32'(data_in) < 32'(NUM_PORTS));
  assign w_hdr_valid     = pkt_valid && w_addr_in_range;
  assign w_sel_empty     = w_addr_in_range ? fifo_empty[data_in] : 1'b0;
  assign w_cur_empty     = fifo_empty[r_cur_addr];
  assign w_cur_soft_rst  = soft_reset[r_cur_addr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= DECODE_ADDRESS;
      r_cur_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DECODE_ADDRESS && w_hdr_valid)
        r_cur_addr <= data_in;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DECODE_ADDRESS: begin
        if (w_hdr_valid)
          w_next_state = w_sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
        else if (pkt_valid)
          w_next_state = DROP_PACKET;
`endif
      end
      WAIT_TILL_EMPTY: begin
        if (w_cur_empty)
          w_next_state = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA:
        w_next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)
          w_next_state = FIFO_FULL_STATE;
        else if (!pkt_valid)
          w_next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)
          w_next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)
          w_next_state = DECODE_ADDRESS;
        else if (low_pkt_valid)
          w_next_state = LOAD_PARITY;
        else
          w_next_state = LOAD_DATA;
      end
      LOAD_PARITY:
        w_next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
      DROP_PACKET: begin
        if (!pkt_valid)
          w_next_state = DECODE_ADDRESS;
      end
`endif
      default:
        w_next_state = DECODE_ADDRESS;
    endcase
    // A read timeout on the active FIFO abandons the packet from any state.
    if (w_cur_soft_rst)
      w_next_state = DECODE_ADDRESS;
  end

  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
  assign busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA) ||
                           (r_state == DROP_PACKET));
`else
  assign busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
`endif
  assign cur_addr      = r_cur_addr;

endmodule

// File: tb/tb_router_fsm.sv
// Directed, table-driven bench for router_fsm; the bad-address rows follow
// ROUTER_FSM_BAD_ADDR_DROP_EN when it is defined.
module tb_router_fsm;
  import router_pkg::*;

  // Output signature {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] S_DEC  = 8'b1000_0000;
  localparam logic [7:0] S_LFD  = 8'b0100_0001;
  localparam logic [7:0] S_LD   = 8'b0010_0100;
  localparam logic [7:0] S_LAF  = 8'b0001_0101;
  localparam logic [7:0] S_FULL = 8'b0000_1001;
  localparam logic [7:0] S_LP   = 8'b0000_0101;
  localparam logic [7:0] S_CPE  = 8'b0000_0011;
  localparam logic [7:0] S_WTE  = 8'b0000_0001;
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
  localparam logic [7:0] S_BAD  = 8'b0000_0000;
`else
  localparam logic [7:0] S_BAD  = S_DEC;
`endif

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] sig;
    logic [1:0] addr;
  } vec_t;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [1:0] cur_addr;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  router_fsm #(.NUM_PORTS(3), .ADDR_W(2)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .cur_addr(cur_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(logic pv, logic [1:0] din, logic ff, logic [2:0] fe,
                              logic [2:0] sr, logic pd, logic lpv,
                              logic [7:0] sig, logic [1:0] addr);
    vec_t v;
    v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.sig = sig; v.addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] exp_sig, input logic [1:0] exp_addr);
    logic [7:0] act_sig;
    act_sig = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy};
    checks++;
    if (act_sig !== exp_sig || cur_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s: got outputs=%b cur_addr=%0d, expected outputs=%b cur_addr=%0d",
               name, act_sig, cur_addr, exp_sig, exp_addr);
    end
  endtask

  task automatic drive(input vec_t v);
    pkt_valid = v.pv; data_in = v.din; fifo_full = v.ff; fifo_empty = v.fe;
    soft_reset = v.sr; parity_done = v.pd; low_pkt_valid = v.lpv;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;

    // packet to port 1 with four payload bytes
    vecs.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd1));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP,  2'd1));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE, 2'd1));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DEC, 2'd1));
    // packet to port 2 waiting for its FIFO, then full back-pressure
    vecs.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL, 2'd2));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2'd2));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL, 2'd2));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2'd2));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, S_LP,  2'd2));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE, 2'd2));
    vecs.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL, 2'd2));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2'd2));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 1, 0, S_DEC, 2'd2));
    // packet to port 0 aborted by soft reset while stalled
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd0));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd0));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL, 2'd0));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b010, 0, 0, S_FULL, 2'd0));
    vecs.push_back(mk(1, 2'd0, 1, 3'b111, 3'b001, 0, 0, S_DEC, 2'd0));
    // header with address 3
    vecs.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_BAD, 2'd0));
    vecs.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_BAD, 2'd0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DEC, 2'd0));
    vecs.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_DEC, 2'd0));

    #2;
    check("reset_state", S_DEC, 2'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), vecs[i].sig, vecs[i].addr);
    end

    // asynchronous reset in the middle of LOAD_DATA
    @(negedge clock);
    drive(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd1));
    @(posedge clock);
    #1;
    check("midrst_lfd", S_LFD, 2'd1);
    @(negedge clock);
    data_in = 2'd0;
    @(posedge clock);
    #1;
    check("midrst_ld", S_LD, 2'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_async", S_DEC, 2'd0);
    @(negedge clock);
    pkt_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_after", S_DEC, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
